// File: rtl/eq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | eq_pkg : shared types and constants for the biquad coefficient    |
// | banks.                                        Revision: 1.0       |
// +------------------------------------------------------------------+
package eq_pkg;

  localparam int NUM_STAGES = 5;
  localparam int COEF_W     = 18;
  localparam int FRAC_BITS  = 16;

  localparam logic [COEF_W-1:0] COEF_UNITY = COEF_W'(1 << FRAC_BITS);

  typedef enum logic [2:0] {
    SLOT_B0 = 3'd0,
    SLOT_B1 = 3'd1,
    SLOT_B2 = 3'd2,
    SLOT_A1 = 3'd3,
    SLOT_A2 = 3'd4
  } coef_slot_e;

  typedef struct packed {
    logic [COEF_W-1:0] b0;
    logic [COEF_W-1:0] b1;
    logic [COEF_W-1:0] b2;
    logic [COEF_W-1:0] a1;
    logic [COEF_W-1:0] a2;
  } biquad_coef_t;

  localparam int BANK_W = NUM_STAGES * $bits(biquad_coef_t);

  localparam biquad_coef_t COEF_PASSTHRU = '{COEF_UNITY, '0, '0, '0, '0};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WRITE    = 3'd1,
    S_ACK_HOLD = 3'd2,
    S_PEND     = 3'd3,
    S_COPY     = 3'd4
  } ctl_state_e;

  function automatic logic stage_valid(input logic [2:0] s);
    return {1'b0, s} < 4'(NUM_STAGES);
  endfunction

endpackage
`default_nettype wire

// File: rtl/coef_bank.sv
`default_nettype none
// +------------------------------------------------------------------+
// | coef_bank : NUM_STAGES x biquad register file, per-slot write,   |
// | bulk load, reset to passthrough.              Revision: 1.0       |
// +------------------------------------------------------------------+
module coef_bank
  import eq_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              wr_en,
  input  logic [2:0]        wr_stage,
  input  logic [2:0]        wr_slot,
  input  logic [COEF_W-1:0] wr_data,
  input  logic              load_en,
  input  logic [BANK_W-1:0] load_data,
  output logic [BANK_W-1:0] bank
);

  biquad_coef_t [NUM_STAGES-1:0] r_bank;

  assign bank = r_bank;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        r_bank[i] <= COEF_PASSTHRU;
      end
    end else if (load_en) begin
      r_bank <= load_data;
    end else if (wr_en && stage_valid(wr_stage)) begin
      case (coef_slot_e'(wr_slot))
        SLOT_B0: r_bank[wr_stage].b0 <= wr_data;
        SLOT_B1: r_bank[wr_stage].b1 <= wr_data;
        SLOT_B2: r_bank[wr_stage].b2 <= wr_data;
        SLOT_A1: r_bank[wr_stage].a1 <= wr_data;
        SLOT_A2: r_bank[wr_stage].a2 <= wr_data;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/coef_bank_controller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | coef_bank_controller : double-buffered biquad coefficient store,  |
// | SW handshake and sample-aligned commit.       Revision: 1.0       |
// +------------------------------------------------------------------+
module coef_bank_controller
  import eq_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              sw_req,
  input  logic              sw_commit,
  input  logic [2:0]        sw_stage,
  input  logic [COEF_W-1:0] sw_coef,
  output logic              sw_ack,
  output logic              sw_err,
  input  logic              sample_tick,
  input  logic [2:0]        rd_stage,
  output logic [COEF_W-1:0] b0,
  output logic [COEF_W-1:0] b1,
  output logic [COEF_W-1:0] b2,
  output logic [COEF_W-1:0] a1,
  output logic [COEF_W-1:0] a2,
  output logic              commit_pending,
  output logic              coefficients_updated
);

  ctl_state_e  r_state;
  logic [2:0]  r_slot;
  logic        w_wr_en;
  logic        w_load;
  logic [BANK_W-1:0] w_shadow;
  logic [BANK_W-1:0] w_active;
  biquad_coef_t [NUM_STAGES-1:0] w_src;
  biquad_coef_t w_rd;
  biquad_coef_t r_rd;

  assign w_wr_en = (r_state == S_WRITE);
  assign w_load  = (r_state == S_COPY);

  coef_bank u_shadow (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .wr_en     (w_wr_en),
    .wr_stage  (sw_stage),
    .wr_slot   (r_slot),
    .wr_data   (sw_coef),
    .load_en   (1'b0),
    .load_data ({BANK_W{1'b0}}),
    .bank      (w_shadow)
  );

  coef_bank u_active (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .wr_en     (1'b0),
    .wr_stage  (3'd0),
    .wr_slot   (3'd0),
    .wr_data   ({COEF_W{1'b0}}),
    .load_en   (w_load),
    .load_data (w_shadow),
    .bank      (w_active)
  );

  // Read from the incoming shadow data during COPY so the new set appears
  // on the outputs in the same cycle as coefficients_updated.
  assign w_src = w_load ? w_shadow : w_active;

  always_comb begin
    w_rd = COEF_PASSTHRU;
    if (stage_valid(rd_stage)) begin
      w_rd = w_src[rd_stage];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rd <= COEF_PASSTHRU;
    end else begin
      r_rd <= w_rd;
    end
  end

  assign b0 = r_rd.b0;
  assign b1 = r_rd.b1;
  assign b2 = r_rd.b2;
  assign a1 = r_rd.a1;
  assign a2 = r_rd.a2;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state              <= S_IDLE;
      r_slot               <= 3'd0;
      sw_ack               <= 1'b0;
      sw_err               <= 1'b0;
      commit_pending       <= 1'b0;
      coefficients_updated <= 1'b0;
    end else begin
      coefficients_updated <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (sw_req) begin
            if (!sw_commit) begin
              r_state <= S_WRITE;
            end else if (r_slot == 3'd0) begin
              r_state        <= S_PEND;
              commit_pending <= 1'b1;
              sw_ack         <= 1'b1;
              sw_err         <= 1'b0;
            end else begin
              // Partial stage in the shadow bank: refuse the commit.
              r_state <= S_ACK_HOLD;
              sw_ack  <= 1'b1;
              sw_err  <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (stage_valid(sw_stage)) begin
            r_slot <= (r_slot == 3'(SLOT_A2)) ? 3'd0 : r_slot + 3'd1;
          end else begin
            sw_err <= 1'b1;
          end
          sw_ack  <= 1'b1;
          r_state <= S_ACK_HOLD;
        end
        S_ACK_HOLD: begin
          if (!sw_req) begin
            sw_ack  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_PEND: begin
          if (sample_tick) begin
            commit_pending <= 1'b0;
            r_state        <= S_COPY;
          end
        end
        S_COPY: begin
          coefficients_updated <= 1'b1;
          r_state              <= S_ACK_HOLD;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_coef_bank_controller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_coef_bank_controller : randomized bench with array model of   |
// | shadow/active banks.                          Revision: 1.0       |
// +------------------------------------------------------------------+
module tb_coef_bank_controller;

  localparam logic [17:0] UNITY = 18'h10000;
  localparam int          NST   = 5;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        sw_req = 1'b0;
  logic        sw_commit = 1'b0;
  logic [2:0]  sw_stage = 3'd0;
  logic [17:0] sw_coef = 18'd0;
  logic        sw_ack;
  logic        sw_err;
  logic        sample_tick = 1'b0;
  logic [2:0]  rd_stage = 3'd0;
  logic [17:0] b0, b1, b2, a1, a2;
  logic        commit_pending;
  logic        coefficients_updated;

  coef_bank_controller dut (
    .Clk                  (Clk),
    .Reset_n              (Reset_n),
    .sw_req               (sw_req),
    .sw_commit            (sw_commit),
    .sw_stage             (sw_stage),
    .sw_coef              (sw_coef),
    .sw_ack               (sw_ack),
    .sw_err               (sw_err),
    .sample_tick          (sample_tick),
    .rd_stage             (rd_stage),
    .b0                   (b0),
    .b1                   (b1),
    .b2                   (b2),
    .a1                   (a1),
    .a2                   (a2),
    .commit_pending       (commit_pending),
    .coefficients_updated (coefficients_updated)
  );

  always #10 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Model: two banks of [stage][coef index 0..4 = b0,b1,b2,a1,a2]
  logic [17:0] m_sh  [NST][5];
  logic [17:0] m_act [NST][5];
  int          m_slot;
  bit          m_err;

  function automatic void m_reset();
    for (int s = 0; s < NST; s++)
      for (int k = 0; k < 5; k++) begin
        m_sh[s][k]  = (k == 0) ? UNITY : 18'd0;
        m_act[s][k] = (k == 0) ? UNITY : 18'd0;
      end
    m_slot = 0;
    m_err  = 0;
  endfunction

  function automatic logic [17:0] m_rd(input int st, input int k);
    if (st < NST) return m_act[st][k];
    return (k == 0) ? UNITY : 18'd0;
  endfunction

  task automatic check_outputs(input string tag);
    int st;
    st = int'(rd_stage);
    check({tag, ".b0"}, 32'(b0), 32'(m_rd(st, 0)));
    check({tag, ".b1"}, 32'(b1), 32'(m_rd(st, 1)));
    check({tag, ".b2"}, 32'(b2), 32'(m_rd(st, 2)));
    check({tag, ".a1"}, 32'(a1), 32'(m_rd(st, 3)));
    check({tag, ".a2"}, 32'(a2), 32'(m_rd(st, 4)));
  endtask

  task automatic read_all(input string tag);
    for (int s = 0; s < 8; s++) begin
      rd_stage = 3'(s);
      @(negedge Clk);
      check_outputs($sformatf("%s.st%0d", tag, s));
    end
  endtask

  task automatic sw_write(input int stage, input logic [17:0] val);
    sw_stage  = 3'(stage);
    sw_coef   = val;
    sw_commit = 1'b0;
    sw_req    = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    check("wr_ack_hi", 32'(sw_ack), 32'd1);
    sw_req = 1'b0;
    @(negedge Clk);
    check("wr_ack_lo", 32'(sw_ack), 32'd0);
    if (stage < NST) begin
      m_sh[stage][m_slot] = val;
      m_slot = (m_slot + 1) % 5;
    end else begin
      m_err = 1;
    end
    check("wr_err", 32'(sw_err), 32'(m_err));
  endtask

  task automatic sw_commit_op(input int delay, input bit same_tick);
    bit accept;
    accept      = (m_slot == 0);
    sw_commit   = 1'b1;
    sw_req      = 1'b1;
    sample_tick = same_tick;
    @(negedge Clk);
    sample_tick = 1'b0;
    check("cm_ack", 32'(sw_ack), 32'd1);
    check("cm_pending", 32'(commit_pending), 32'(accept));
    if (accept) begin
      repeat (delay) @(negedge Clk);
      check("cm_wait_pending", 32'(commit_pending), 32'd1);
      check("cm_wait_ack", 32'(sw_ack), 32'd1);
      check_outputs("cm_wait_out");
      sample_tick = 1'b1;
      @(negedge Clk);
      sample_tick = 1'b0;
      check("cm_upd_early", 32'(coefficients_updated), 32'd0);
      check("cm_pending_drop", 32'(commit_pending), 32'd0);
      @(negedge Clk);
      for (int s = 0; s < NST; s++)
        for (int k = 0; k < 5; k++) m_act[s][k] = m_sh[s][k];
      m_err = 0;
      check("cm_upd", 32'(coefficients_updated), 32'd1);
      check_outputs("cm_copy_vis");
      check("cm_ack_held", 32'(sw_ack), 32'd1);
      sw_req = 1'b0;
      @(negedge Clk);
      check("cm_upd_pulse", 32'(coefficients_updated), 32'd0);
      check("cm_ack_rel", 32'(sw_ack), 32'd0);
    end else begin
      m_err  = 1;
      sw_req = 1'b0;
      @(negedge Clk);
      check("cm_rej_ack_rel", 32'(sw_ack), 32'd0);
      check("cm_rej_upd", 32'(coefficients_updated), 32'd0);
    end
    sw_commit = 1'b0;
    check("cm_err", 32'(sw_err), 32'(m_err));
  endtask

  initial begin
    logic [17:0] vals [5];
    m_reset();
    repeat (3) @(negedge Clk);
    check("rst_ack", 32'(sw_ack), 32'd0);
    check("rst_pending", 32'(commit_pending), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);
    check("rst_err", 32'(sw_err), 32'd0);
    check("rst_upd", 32'(coefficients_updated), 32'd0);
    read_all("rst");

    // Stage 2 programmed with signed values, then committed
    vals = '{18'd1000, 18'd2000, 18'd3000, 18'(-4000), 18'd5000};
    for (int k = 0; k < 5; k++) sw_write(2, vals[k]);
    rd_stage = 3'd2;
    @(negedge Clk);
    sw_commit_op(3, 1'b0);
    read_all("st2");

    // Long pending commit with a tick coinciding with commit entry
    for (int k = 0; k < 5; k++) sw_write(1, 18'($urandom));
    rd_stage = 3'd1;
    @(negedge Clk);
    sw_commit_op(200, 1'b1);

    // Partial stage commit refused, then completed
    for (int k = 0; k < 3; k++) sw_write(3, 18'($urandom));
    sw_commit_op(0, 1'b0);
    read_all("partial");
    sw_write(3, 18'($urandom));
    sw_write(3, 18'($urandom));
    sw_commit_op(1, 1'b0);
    check("partial_err_clr", 32'(sw_err), 32'd0);
    read_all("partial_done");

    // Out-of-range stage: dropped, slot held
    sw_write(7, 18'h2abcd);
    check("bad_stage_err", 32'(sw_err), 32'd1);
    for (int k = 0; k < 5; k++) sw_write(4, 18'($urandom));
    sw_commit_op(2, 1'b0);
    read_all("bad_stage");

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        int st;
        st = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
        sw_write(st, 18'($urandom));
      end else begin
        sw_commit_op(int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 1) == 1) begin
        sample_tick = 1'b1;
        @(negedge Clk);
        sample_tick = 1'b0;
        check("rnd_stray_tick_upd", 32'(coefficients_updated), 32'd0);
      end
      rd_stage = 3'($urandom_range(0, 7));
      @(negedge Clk);
      check_outputs("rnd");
    end
    read_all("rnd_end");

    // Reset while pending
    while (m_slot != 0) sw_write(0, 18'($urandom));
    for (int k = 0; k < 5; k++) sw_write(0, 18'($urandom));
    sw_commit = 1'b1;
    sw_req    = 1'b1;
    @(negedge Clk);
    check("rp_pending", 32'(commit_pending), 32'd1);
    repeat (3) @(negedge Clk);
    Reset_n   = 1'b0;
    sw_req    = 1'b0;
    sw_commit = 1'b0;
    #3;
    check("rp_pending_clr", 32'(commit_pending), 32'd0);
    check("rp_ack_clr", 32'(sw_ack), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    m_reset();
    sample_tick = 1'b1;
    @(negedge Clk);
    sample_tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("rp_no_upd", 32'(coefficients_updated), 32'd0);
    end
    check("rp_err", 32'(sw_err), 32'd0);
    read_all("rp");
    // Shadow must also be back at passthrough
    sw_commit_op(1, 1'b0);
    read_all("rp_shadow");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
